perm_inverse_stream: RTL and testbench
======================================

Name: perm_inverse_stream

Overview:
Consumer-side block for the random-permutation generator. It accepts a permutation of 0..N-1 as a valid/ready stream, one index per beat in position order. It builds the inverse permutation (inv[p[k]] = k) and streams the inverse out, also in position order. With checking compiled in, it also flags inputs that are not legal permutations, so downstream shufflers can de-shuffle or audit generator output.

Parameters:
N, 100, permutation length; legal range 2..1024.
W, $clog2(N), index width; derived, never overridden.

Ports:
clk  input  1  clock; rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept an input beat.
in_data  input  W  permutation entry p[k]; k is implicit from beat order.
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accepts the output beat.
out_data  output  W  inverse entry inv[j]; j is implicit from beat order.
out_last  output  1  high with the beat for j = N-1.
done  output  1  one-cycle pulse after the last output beat is accepted.
error  output  1  sticky flag: illegal permutation detected.
err_clr  input  1  synchronous pulse; clears error and returns FSM to LOAD.

Behaviour:
- Reset values (asynchronous): state=LOAD, wr_cnt=0, rd_cnt=0, out_valid=0, out_last=0, done=0, error=0, seen bitmap all 0. Contents of inv[] are don't-care.
- Transfer rule: a beat transfers when valid&&ready are both high on a rising edge. Upstream holds in_data stable while in_valid=1 and in_ready=0.
- LOAD state:
  - in_ready=1.
  - On each transfer: inv[in_data] <= wr_cnt; seen[in_data] <= 1; wr_cnt++.
  - On the transfer where wr_cnt==N-1: wr_cnt <= 0. Next state is EMIT if no error has been flagged and error will not be set by this beat; otherwise DRAIN_ERR.
- EMIT state:
  - in_ready=0, out_valid=1.
  - out_data=inv[rd_cnt], read from registers with no path from in_*.
  - out_last=(rd_cnt==N-1).
  - On each transfer: rd_cnt++. On the last beat: rd_cnt <= 0, seen cleared, state <= LOAD, done=1 in the following cycle.
- Latency: the first out_valid is asserted the cycle after the Nth input transfer. With out_ready tied high, the N output beats occupy N consecutive cycles.
- Back-pressure: while out_ready=0, out_valid, out_data and out_last hold stable. No beat is skipped or duplicated.
- DRAIN_ERR state:
  - Entered on the Nth beat when error=1.
  - in_ready=0, out_valid=0.
  - The block holds here until err_clr is pulsed.
  - err_clr clears error, seen, wr_cnt and rd_cnt, then the state goes to LOAD.
- Error detection (PERM_INV_CHECK_EN only), evaluated on each LOAD transfer:
  - in_data >= N: range error.
  - seen[in_data]==1: duplicate.
  - Either case sets error the next cycle. Loading continues until N beats have been taken, so stream framing stays intact. The write to inv[] is suppressed for out-of-range values.
- err_clr in LOAD or EMIT: aborts the current frame; counters and seen are cleared; state goes to LOAD; no done pulse.
- Asynchronous reset mid-frame: all state is abandoned immediately. Outputs take their reset values. The partial frame is discarded.
- done and error are never asserted in the same cycle by the same frame.

Optional Feature:
PERM_INV_CHECK_EN
- Defined: the seen bitmap (N flops), range/duplicate checking and the DRAIN_ERR state are built.
- Undefined:
  - No seen bitmap; error is tied to 0; DRAIN_ERR is unreachable.
  - Illegal input produces an undefined inverse, but framing is unchanged (N beats in, N beats out).
  - Out-of-range writes are masked so array bounds are never exceeded.
  - err_clr still aborts the current frame.

Decomposition:
- Shared package perm_pkg holds:
  - state enum typedef {LOAD, EMIT, DRAIN_ERR};
  - localparam function for the index width (clog2);
  - the default length constant PERM_N_DEFAULT=100, shared with the generator.
- One sub-module is natural: perm_inv_ram, an N x W register array with one synchronous write port and one asynchronous read port. It keeps the array separable for a later swap to an inferred RAM.
- The FSM, counters and seen bitmap stay in the top module.

Test Plan:
- N=4, identity input 0,1,2,3, out_ready=1 -> output 0,1,2,3 on 4 consecutive cycles starting 1 cycle after the 4th accept; out_last on 3; done pulses once; error=0.
- N=4, input 2,0,3,1 -> output 1,3,0,2; then a second frame 3,2,1,0 -> output 3,2,1,0 (checks back-to-back frame re-arm).
- N=4, out_ready toggling 1,0,0,1,0,1,1 -> every output beat appears exactly once with data held stable while stalled; done only after beat j=3 is accepted.
- CHECK_EN, N=4, input 1,1,0,2 -> error=1 the cycle after beat 2; all 4 beats still accepted; state DRAIN_ERR, out_valid stays 0. err_clr then returns to LOAD; the next legal frame 3,0,1,2 -> 1,2,3,0.
- CHECK_EN, N=5 (W=3), input 0,6,1,2,3 -> range error flagged; inv[] untouched for value 6; no output beats.
- Assert reset during EMIT after 2 of 4 beats -> out_valid=0 immediately; next frame 1,0,3,2 -> 1,0,3,2 with no residue from the aborted frame.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared definitions for the random-permutation generator and its consumers:
// the frame-length default, the index-width helper and the consumer FSM states.
package perm_pkg;

    localparam int PERM_N_DEFAULT = 100;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        EMIT      = 2'd1,
        DRAIN_ERR = 2'd2
    } perm_state_e;

    // A length of 1 still needs one address bit.
    function automatic int perm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perm_inverse_stream_if.sv
// Valid/ready stream pair of perm_inverse_stream: permutation beats in, inverse beats out.
// master = upstream/downstream side, slave = the inverting block.
interface perm_inverse_stream_if
    import perm_pkg::*;
#(
    parameter int W = perm_idx_w(PERM_N_DEFAULT)
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/perm_inv_ram.sv
// N x W register array holding the inverse permutation: one synchronous write port,
// one asynchronous read port, kept separate so it can later become an inferred RAM.
module perm_inv_ram #(
    parameter int N = 100,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [W-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic [W-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);

    logic [W-1:0] mem_q [N];

    // NOTE: storage has no reset; every entry is rewritten before it is read, and
    // leaving it unreset lets the array map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/perm_inverse_stream.sv
// Builds inv[p[k]] = k from a streamed permutation and streams the inverse back out.
// Define PERM_INV_CHECK_EN to build the seen bitmap, range/duplicate checks and DRAIN_ERR.
module perm_inverse_stream
    import perm_pkg::*;
#(
    parameter int N = PERM_N_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    perm_inverse_stream_if.slave        bus,
    output logic                        done,
    output logic                        error,
    input  logic                        err_clr
);

    localparam int              W        = perm_idx_w(N);
    localparam logic [W-1:0]    LAST_IDX = W'(N - 1);
    localparam logic [W:0]      N_EXT    = (W + 1)'(N);

    localparam logic [1:0] S_LOAD      = LOAD;
    localparam logic [1:0] S_EMIT      = EMIT;
    localparam logic [1:0] S_DRAIN_ERR = DRAIN_ERR;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] wr_cnt_q, wr_cnt_d;
    logic [W-1:0] rd_cnt_q, rd_cnt_d;
    logic         done_q, done_d;

    logic         in_fire, out_fire, range_ok, wr_en, frame_bad;
    logic [W-1:0] rd_data;

    // Outputs decode registered state only, so out_* has no path from in_*.
    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.out_valid = (state_q == S_EMIT);
    assign bus.out_last  = bus.out_valid && (rd_cnt_q == LAST_IDX);
    assign bus.out_data  = rd_data;
    assign done          = done_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign range_ok = ({1'b0, bus.in_data} < N_EXT);
    assign wr_en    = in_fire && range_ok && !err_clr;

    perm_inv_ram #(.N(N), .W(W)) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (bus.in_data),
        .wdata_i (wr_cnt_q),
        .raddr_i (rd_cnt_q),
        .rdata_o (rd_data)
    );

`ifdef PERM_INV_CHECK_EN
    logic [N-1:0] seen_q, seen_d;
    logic         error_q, error_d;
    logic         err_hit;

    assign err_hit   = in_fire && (!range_ok || seen_q[bus.in_data]);
    assign frame_bad = error_q || err_hit;
    assign error     = error_q;

    always_comb begin
        seen_d  = seen_q;
        error_d = error_q;
        if (err_clr) begin
            seen_d  = '0;
            error_d = 1'b0;
        end else begin
            if (wr_en) begin
                seen_d[bus.in_data] = 1'b1;
            end
            if (err_hit) begin
                error_d = 1'b1;
            end
            if (out_fire && bus.out_last) begin
                seen_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q  <= '0;
            error_q <= 1'b0;
        end else begin
            seen_q  <= seen_d;
            error_q <= error_d;
        end
    end
`else
    assign frame_bad = 1'b0;
    assign error     = 1'b0;
`endif

    // NOTE: every next-state variable gets its default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        done_d   = 1'b0;
        if (err_clr) begin
            // Abort wins over any beat in the same cycle; the frame is dropped.
            state_d  = S_LOAD;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire) begin
                        if (wr_cnt_q == LAST_IDX) begin
                            wr_cnt_d = '0;
                            state_d  = frame_bad ? S_DRAIN_ERR : S_EMIT;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_fire) begin
                        if (rd_cnt_q == LAST_IDX) begin
                            rd_cnt_d = '0;
                            state_d  = S_LOAD;
                            done_d   = 1'b1;
                        end else begin
                            rd_cnt_d = rd_cnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN_ERR: begin
                    state_d = S_DRAIN_ERR;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_perm_inverse_stream.sv
// Directed bench for perm_inverse_stream with an N=4 and an N=5 instance; the
// error-path expectations follow whether PERM_INV_CHECK_EN is defined.
module tb_perm_inverse_stream;
    import perm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr4 = 1'b0;
    logic clr5 = 1'b0;
    logic done4, error4, done5, error5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    perm_inverse_stream_if #(.W(perm_idx_w(4))) b4 ();
    perm_inverse_stream_if #(.W(perm_idx_w(5))) b5 ();

    perm_inverse_stream #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .bus(b4), .done(done4), .error(error4), .err_clr(clr4)
    );

    perm_inverse_stream #(.N(5)) dut5 (
        .clk(clk), .reset(reset), .bus(b5), .done(done5), .error(error5), .err_clr(clr5)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat k of a frame lives in bits [2k+1:2k].
    task automatic send4(input logic [7:0] frame);
        for (int k = 0; k < 4; k++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = frame[2*k +: 2];
            check("in_ready4", b4.in_ready, 1);
            tick();
        end
        b4.in_valid = 1'b0;
    endtask

    // pat bit c is out_ready during cycle c; j advances on each accepted beat.
    task automatic recv4(input logic [7:0] exp, input logic [15:0] pat, input int ncyc);
        int j = 0;
        for (int c = 0; c < ncyc; c++) begin
            b4.out_ready = pat[c];
            check("out_valid4", b4.out_valid, 1);
            check("out_data4", b4.out_data, exp[2*j +: 2]);
            check("out_last4", b4.out_last, (j == 3));
            check("done4_early", done4, 0);
            tick();
            if (pat[c]) j++;
        end
        b4.out_ready = 1'b0;
        check("done4_pulse", done4, 1);
        check("out_valid4_after", b4.out_valid, 0);
        check("in_ready4_rearm", b4.in_ready, 1);
        check("error4_frame", error4, 0);
        tick();
        check("done4_single", done4, 0);
    endtask

    task automatic send5(input logic [14:0] frame);
        for (int k = 0; k < 5; k++) begin
            b5.in_valid = 1'b1;
            b5.in_data  = frame[3*k +: 3];
            check("in_ready5", b5.in_ready, 1);
            tick();
        end
        b5.in_valid = 1'b0;
    endtask

    task automatic recv5(input logic [14:0] exp);
        b5.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("out_valid5", b5.out_valid, 1);
            check("out_data5", b5.out_data, exp[3*j +: 3]);
            check("out_last5", b5.out_last, (j == 4));
            tick();
        end
        b5.out_ready = 1'b0;
        check("done5_pulse", done5, 1);
        tick();
    endtask

    initial begin
        logic [7:0]  dup;
        logic [14:0] rng;

        b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b0;

        // Reset state
        tick();
        check("rst_out_valid4", b4.out_valid, 0);
        check("rst_out_last4", b4.out_last, 0);
        check("rst_done4", done4, 0);
        check("rst_error4", error4, 0);
        check("rst_in_ready4", b4.in_ready, 1);
        check("rst_out_valid5", b5.out_valid, 0);
        tick();
        reset = 1'b0;
        tick();

        // Identity 0,1,2,3 -> 0,1,2,3, out_ready held high
        send4({2'd3, 2'd2, 2'd1, 2'd0});
        recv4({2'd3, 2'd2, 2'd1, 2'd0}, 16'hFFFF, 4);

        // 2,0,3,1 -> 1,3,0,2, then 3,2,1,0 -> 3,2,1,0
        send4({2'd1, 2'd3, 2'd0, 2'd2});
        recv4({2'd2, 2'd0, 2'd3, 2'd1}, 16'hFFFF, 4);
        send4({2'd0, 2'd1, 2'd2, 2'd3});
        recv4({2'd0, 2'd1, 2'd2, 2'd3}, 16'hFFFF, 4);

        // 1,2,3,0 -> 3,0,1,2 with out_ready 1,0,0,1,0,1,1
        send4({2'd0, 2'd3, 2'd2, 2'd1});
        recv4({2'd2, 2'd1, 2'd0, 2'd3}, 16'h0069, 7);

        // Abort after two beats, then a full frame 2,0,3,1 -> 1,3,0,2
        for (int k = 0; k < 2; k++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = 2'(k);
            tick();
        end
        b4.in_valid = 1'b0;
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        check("abort_done4", done4, 0);
        check("abort_in_ready4", b4.in_ready, 1);
        check("abort_error4", error4, 0);
        send4({2'd1, 2'd3, 2'd0, 2'd2});
        recv4({2'd2, 2'd0, 2'd3, 2'd1}, 16'hFFFF, 4);

        // Duplicate frame 1,1,0,2
        dup = {2'd2, 2'd0, 2'd1, 2'd1};
        for (int k = 0; k < 4; k++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = dup[2*k +: 2];
            check("dup_in_ready4", b4.in_ready, 1);
            tick();
`ifdef PERM_INV_CHECK_EN
            check("dup_error4", error4, (k >= 1));
`else
            check("dup_error4", error4, 0);
`endif
        end
        b4.in_valid = 1'b0;
`ifdef PERM_INV_CHECK_EN
        b4.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("drain_out_valid4", b4.out_valid, 0);
            check("drain_in_ready4", b4.in_ready, 0);
            check("drain_done4", done4, 0);
            check("drain_error4", error4, 1);
            tick();
        end
        b4.out_ready = 1'b0;
`else
        b4.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("dup_out_valid4", b4.out_valid, 1);
            check("dup_out_last4", b4.out_last, (j == 3));
            tick();
        end
        b4.out_ready = 1'b0;
        check("dup_done4", done4, 1);
        tick();
`endif
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        check("clr_error4", error4, 0);
        check("clr_in_ready4", b4.in_ready, 1);
        check("clr_done4", done4, 0);
        // 3,0,1,2 -> 1,2,3,0
        send4({2'd2, 2'd1, 2'd0, 2'd3});
        recv4({2'd0, 2'd3, 2'd2, 2'd1}, 16'hFFFF, 4);

        // N=5 range error: 0,6,1,2,3
        rng = {3'd3, 3'd2, 3'd1, 3'd6, 3'd0};
        for (int k = 0; k < 5; k++) begin
            b5.in_valid = 1'b1;
            b5.in_data  = rng[3*k +: 3];
            check("rng_in_ready5", b5.in_ready, 1);
            tick();
`ifdef PERM_INV_CHECK_EN
            check("rng_error5", error5, (k >= 1));
`else
            check("rng_error5", error5, 0);
`endif
        end
        b5.in_valid = 1'b0;
        b5.out_ready = 1'b1;
`ifdef PERM_INV_CHECK_EN
        for (int c = 0; c < 3; c++) begin
            check("rng_out_valid5", b5.out_valid, 0);
            check("rng_in_ready5_drain", b5.in_ready, 0);
            check("rng_done5", done5, 0);
            tick();
        end
`else
        for (int j = 0; j < 5; j++) begin
            check("rng_out_valid5", b5.out_valid, 1);
            check("rng_out_last5", b5.out_last, (j == 4));
            tick();
        end
        check("rng_done5", done5, 1);
        tick();
`endif
        b5.out_ready = 1'b0;
        clr5 = 1'b1;
        tick();
        clr5 = 1'b0;
        check("clr_error5", error5, 0);
        // 4,3,2,1,0 -> 4,3,2,1,0
        send5({3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        recv5({3'd0, 3'd1, 3'd2, 3'd3, 3'd4});

        // Reset during EMIT after two of four beats
        send4({2'd3, 2'd2, 2'd1, 2'd0});
        b4.out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            check("pre_rst_data4", b4.out_data, j);
            tick();
        end
        b4.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid4", b4.out_valid, 0);
        check("mid_rst_out_last4", b4.out_last, 0);
        check("mid_rst_done4", done4, 0);
        tick();
        reset = 1'b0;
        tick();
        // 1,0,3,2 -> 1,0,3,2
        send4({2'd2, 2'd3, 2'd0, 2'd1});
        recv4({2'd2, 2'd3, 2'd0, 2'd1}, 16'hFFFF, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
